// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_arbiter_pkg;

  localparam int XLEN    = 32;
  localparam int ROB_W   = 6;
  localparam int PHYS_W  = 7;
  localparam int EPOCH_W = 2;

  // One execution-unit result as it travels towards the CDB.
  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic               uses_rd;
    logic [ROB_W-1:0]   rob_idx;
    logic [PHYS_W-1:0]  prd_new;
    logic [EPOCH_W-1:0] epoch;
    logic [XLEN-1:0]    data;
  } wb_pkt_t;

  // Width of an index that selects one of n channels (at least one bit).
  function automatic int src_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result channels, epoch/flush control and CDB broadcast of the writeback arbiter.
interface wb_arbiter_if #(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
);
  localparam int XLEN    = wb_arbiter_pkg::XLEN;
  localparam int ROB_W   = wb_arbiter_pkg::ROB_W;
  localparam int PHYS_W  = wb_arbiter_pkg::PHYS_W;
  localparam int EPOCH_W = wb_arbiter_pkg::EPOCH_W;
  localparam int SRC_W   = wb_arbiter_pkg::src_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0]         src_valid;
  logic [NUM_SRC-1:0]         src_ready;
  logic [NUM_SRC*XLEN-1:0]    src_pc;
  logic [NUM_SRC-1:0]         src_uses_rd;
  logic [NUM_SRC*ROB_W-1:0]   src_rob_idx;
  logic [NUM_SRC*PHYS_W-1:0]  src_prd_new;
  logic [NUM_SRC*EPOCH_W-1:0] src_epoch;
  logic [NUM_SRC*XLEN-1:0]    src_data;
  logic [EPOCH_W-1:0]         cur_epoch;
  logic                       flush;
  logic                       cdb_valid;
  logic                       cdb_ready;
  logic [XLEN-1:0]            cdb_pc;
  logic                       cdb_uses_rd;
  logic [ROB_W-1:0]           cdb_rob_idx;
  logic [PHYS_W-1:0]          cdb_prd_new;
  logic [XLEN-1:0]            cdb_data;
  logic [SRC_W-1:0]           cdb_src;
  logic [CNT_W-1:0]           drop_cnt;

  // Execution units, ROB and CDB consumers.
  modport master (
    output src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
    output cur_epoch, flush, cdb_ready,
    input  src_ready, cdb_valid, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_data,
    input  cdb_src, drop_cnt
  );

  // The arbiter itself.
  modport slave (
    input  src_valid, src_pc, src_uses_rd, src_rob_idx, src_prd_new, src_epoch, src_data,
    input  cur_epoch, flush, cdb_ready,
    output src_ready, cdb_valid, cdb_pc, cdb_uses_rd, cdb_rob_idx, cdb_prd_new, cdb_data,
    output cdb_src, drop_cnt
  );
endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin requester selection; owns the rotation pointer.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = src_idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             adv,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_gnt
);

  logic [IDX_W-1:0] rr_ptr_r;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             any_s;
  logic             hit_s;
  int               cand_s;

  // Search upward from the pointer, wrapping once, for the first requester
  always_comb begin
    gnt_idx_s = '0;
    any_s     = 1'b0;
    hit_s     = 1'b0;
    cand_s    = 0;
    for (int k = 0; k < N; k++) begin
      // rr_ptr_r is always below N, so a single subtraction performs the wrap
      cand_s    = (int'(rr_ptr_r) + k >= N) ? int'(rr_ptr_r) + k - N : int'(rr_ptr_r) + k;
      hit_s     = req[cand_s] && !any_s;
      gnt_idx_s = hit_s ? IDX_W'(cand_s) : gnt_idx_s;
      any_s     = any_s | req[cand_s];
    end
  end

  // Expand the winning index into a one-hot grant vector
  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = any_s && (gnt_idx_s == IDX_W'(i));
    end
  end

  assign gnt_idx = gnt_idx_s;
  assign any_gnt = any_s;

  // Move the pointer just past the channel that won an accepted grant
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= '0;
    end else if (adv && any_s) begin
      rr_ptr_r <= (gnt_idx_s == IDX_W'(N - 1)) ? '0 : gnt_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: drains stale results, grants one live result per cycle
// into a single-entry CDB buffer.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int SRC_W = src_idx_w(NUM_SRC);

  logic [NUM_SRC-1:0] stale_s;
  logic [NUM_SRC-1:0] live_s;
  logic [NUM_SRC-1:0] gnt_s;
  logic [SRC_W-1:0]   gnt_idx_s;
  logic               any_gnt_s;
  logic               deq_s;
  logic               can_acc_s;
  logic               acc_s;
  wb_pkt_t            sel_pkt_s;
  logic [CNT_W-1:0]   stale_cnt_s;
  logic [CNT_W:0]     drop_sum_s;

  logic               out_vld_r;
  logic [XLEN-1:0]    pc_r;
  logic               uses_rd_r;
  logic [ROB_W-1:0]   rob_idx_r;
  logic [PHYS_W-1:0]  prd_new_r;
  logic [XLEN-1:0]    data_r;
  logic [SRC_W-1:0]   src_r;
  logic [CNT_W-1:0]   drop_cnt_r;

  // Split valid channels into stale (wrong epoch) and live ones
  always_comb begin
    stale_s = '0;
    live_s  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      stale_s[i] = bus.src_valid[i] && (bus.src_epoch[i*EPOCH_W +: EPOCH_W] != bus.cur_epoch);
      live_s[i]  = bus.src_valid[i] && !stale_s[i];
    end
  end

  assign deq_s     = out_vld_r && bus.cdb_ready;
  assign can_acc_s = !bus.flush && (!out_vld_r || deq_s);

  rr_arbiter #(.N(NUM_SRC), .IDX_W(SRC_W)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (live_s),
    .adv     (can_acc_s),
    .gnt     (gnt_s),
    .gnt_idx (gnt_idx_s),
    .any_gnt (any_gnt_s)
  );

  // One-hot AND-OR mux of the granted channel's payload
  always_comb begin
    sel_pkt_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_pkt_s.pc      = sel_pkt_s.pc      | (bus.src_pc[i*XLEN +: XLEN]           & {XLEN{gnt_s[i]}});
      sel_pkt_s.uses_rd = sel_pkt_s.uses_rd | (bus.src_uses_rd[i]                   & gnt_s[i]);
      sel_pkt_s.rob_idx = sel_pkt_s.rob_idx | (bus.src_rob_idx[i*ROB_W +: ROB_W]    & {ROB_W{gnt_s[i]}});
      sel_pkt_s.prd_new = sel_pkt_s.prd_new | (bus.src_prd_new[i*PHYS_W +: PHYS_W] & {PHYS_W{gnt_s[i]}});
      sel_pkt_s.epoch   = sel_pkt_s.epoch   | (bus.src_epoch[i*EPOCH_W +: EPOCH_W]  & {EPOCH_W{gnt_s[i]}});
      sel_pkt_s.data    = sel_pkt_s.data    | (bus.src_data[i*XLEN +: XLEN]         & {XLEN{gnt_s[i]}});
    end
  end

  // The grant is live by construction; the epoch term guarantees a stale
  // payload can never be loaded even if the grant logic were disturbed.
  assign acc_s = !rst && can_acc_s && any_gnt_s && (sel_pkt_s.epoch == bus.cur_epoch);

  // Stale channels drain unconditionally; the winner only when accepted
  assign bus.src_ready = rst ? {NUM_SRC{1'b0}} : (stale_s | (acc_s ? gnt_s : {NUM_SRC{1'b0}}));

  // Count this cycle's drained stale results and form the widened sum
  always_comb begin
    stale_cnt_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      stale_cnt_s = stale_cnt_s + CNT_W'(stale_s[i]);
    end
    drop_sum_s = {1'b0, drop_cnt_r} + {1'b0, stale_cnt_s};
  end

  // Single-entry CDB buffer and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_r  <= 1'b0;
      pc_r       <= '0;
      uses_rd_r  <= 1'b0;
      rob_idx_r  <= '0;
      prd_new_r  <= '0;
      data_r     <= '0;
      src_r      <= '0;
      drop_cnt_r <= '0;
    end else begin
      drop_cnt_r <= drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];
      if (bus.flush) begin
        out_vld_r <= 1'b0;
      end else if (acc_s) begin
        out_vld_r <= 1'b1;
        pc_r      <= sel_pkt_s.pc;
        uses_rd_r <= sel_pkt_s.uses_rd;
        rob_idx_r <= sel_pkt_s.rob_idx;
        prd_new_r <= sel_pkt_s.prd_new;
        data_r    <= sel_pkt_s.data;
        src_r     <= gnt_idx_s;
      end else if (deq_s) begin
        out_vld_r <= 1'b0;
      end else begin
        out_vld_r <= out_vld_r;
      end
    end
  end

  assign bus.cdb_valid   = out_vld_r;
  assign bus.cdb_pc      = pc_r;
  assign bus.cdb_uses_rd = uses_rd_r;
  assign bus.cdb_rob_idx = rob_idx_r;
  assign bus.cdb_prd_new = prd_new_r;
  assign bus.cdb_data    = data_r;
  assign bus.cdb_src     = src_r;
  assign bus.drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, counter saturation run and
// random traffic, all checked against a cycle-level reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int N     = 3;
  localparam int CNT_W = 16;
  localparam int MAXC  = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arbiter_if #(.NUM_SRC(N), .CNT_W(CNT_W)) bus ();
  wb_arbiter #(.NUM_SRC(N), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  // Channel stimulus state
  logic              ch_vld  [N];
  logic [1:0]        ch_ep   [N];
  logic [31:0]       ch_pc   [N];
  logic              ch_uses [N];
  logic [ROB_W-1:0]  ch_rob  [N];
  logic [PHYS_W-1:0] ch_prd  [N];
  logic [31:0]       ch_data [N];
  logic [1:0]        tb_cur;
  logic              tb_flush;
  logic              tb_rdy;
  logic [N-1:0]      seen_ready;

  // Reference model state
  bit          m_vld;
  int          m_src, m_ptr, m_drop;
  logic [31:0] m_pc, m_data;
  logic        m_uses;
  logic [ROB_W-1:0]  m_rob;
  logic [PHYS_W-1:0] m_prd;

  logic [31:0]      fixed_data [N] = '{32'h0000_0005, 32'h0000_0011, 32'h0000_0022};
  logic [ROB_W-1:0] fixed_rob  [N] = '{6'd3, 6'd1, 6'd2};

  typedef struct {
    bit       rst;
    bit [2:0] vld;
    bit [5:0] ep;    // {ch2, ch1, ch0}
    bit [1:0] cur;
    bit       fl;
    bit       rdy;
    bit [2:0] e_rdy;
    bit       e_cv;
    int       e_src;
    int       e_drop;
  } row_t;

  row_t rows[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      bus.src_valid[i]          = ch_vld[i];
      bus.src_epoch[i*2 +: 2]   = ch_ep[i];
      bus.src_pc[i*32 +: 32]    = ch_pc[i];
      bus.src_uses_rd[i]        = ch_uses[i];
      bus.src_rob_idx[i*ROB_W +: ROB_W]   = ch_rob[i];
      bus.src_prd_new[i*PHYS_W +: PHYS_W] = ch_prd[i];
      bus.src_data[i*32 +: 32]  = ch_data[i];
    end
    bus.cur_epoch = tb_cur;
    bus.flush     = tb_flush;
    bus.cdb_ready = tb_rdy;
  endtask

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic tick();
    bit [N-1:0] exp_rdy;
    int g, nst, c;
    bit can;
    drive_bus();
    #2;
    exp_rdy = '0;
    g   = -1;
    nst = 0;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (ch_vld[i] && ch_ep[i] != tb_cur) begin
          exp_rdy[i] = 1'b1;
          nst++;
        end
      end
      can = !tb_flush && (!m_vld || tb_rdy);
      if (can) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (g < 0 && ch_vld[c] && ch_ep[c] == tb_cur) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    seen_ready = bus.src_ready;
    chk("src_ready", seen_ready, exp_rdy);
    @(posedge clk);
    if (rst) begin
      m_vld = 0; m_ptr = 0; m_drop = 0; m_src = 0;
      m_pc = '0; m_data = '0; m_uses = 1'b0; m_rob = '0; m_prd = '0;
    end else begin
      m_drop = (m_drop + nst > MAXC) ? MAXC : m_drop + nst;
      if (tb_flush) m_vld = 0;
      else if (g >= 0) begin
        m_vld = 1; m_src = g;
        m_pc = ch_pc[g]; m_data = ch_data[g]; m_uses = ch_uses[g];
        m_rob = ch_rob[g]; m_prd = ch_prd[g];
        m_ptr = (g + 1) % N;
      end else if (m_vld && tb_rdy) m_vld = 0;
    end
    #1;
    chk("cdb_valid", bus.cdb_valid, m_vld);
    chk("drop_cnt", bus.drop_cnt, m_drop);
    if (m_vld) begin
      chk("cdb_src", bus.cdb_src, m_src);
      chk("cdb_data", bus.cdb_data, m_data);
      chk("cdb_pc", bus.cdb_pc, m_pc);
      chk("cdb_rob_idx", bus.cdb_rob_idx, m_rob);
      chk("cdb_prd_new", bus.cdb_prd_new, m_prd);
      chk("cdb_uses_rd", bus.cdb_uses_rd, m_uses);
    end
  endtask

  task automatic apply_row(input row_t r);
    rst = r.rst;
    for (int i = 0; i < N; i++) begin
      ch_vld[i] = r.vld[i];
      ch_ep[i]  = r.ep[2*i +: 2];
    end
    tb_cur = r.cur; tb_flush = r.fl; tb_rdy = r.rdy;
    tick();
    chk("tbl_ready", seen_ready, r.e_rdy);
    chk("tbl_cdb_valid", bus.cdb_valid, r.e_cv);
    chk("tbl_drop_cnt", bus.drop_cnt, r.e_drop);
    if (r.e_cv) begin
      chk("tbl_cdb_src", bus.cdb_src, r.e_src);
      chk("tbl_cdb_data", bus.cdb_data, fixed_data[r.e_src]);
      chk("tbl_cdb_rob_idx", bus.cdb_rob_idx, fixed_rob[r.e_src]);
    end
    if (r.rst) chk("tbl_reset_data", bus.cdb_data, 32'h0);
  endtask

  initial begin
    rst = 1'b1; tb_cur = 2'd0; tb_flush = 1'b0; tb_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      ch_vld[i] = 1'b0; ch_ep[i] = 2'd0;
      ch_pc[i] = 32'h1000 + 32'(4*i); ch_uses[i] = 1'b1;
      ch_rob[i] = fixed_rob[i]; ch_prd[i] = PHYS_W'(10 + i); ch_data[i] = fixed_data[i];
    end
    m_vld = 0; m_ptr = 0; m_drop = 0; m_src = 0;

    //              rst vld     ep         cur fl rdy e_rdy   cv src drop
    rows.push_back('{1, 3'b000, 6'b000000, 0, 0, 1, 3'b000, 0, 0, 0});
    rows.push_back('{1, 3'b111, 6'b000000, 0, 0, 1, 3'b000, 0, 0, 0});
    // all channels live: strict rotation 0,1,2,0,1,2
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b001, 1, 0, 0});
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b010, 1, 1, 0});
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b100, 1, 2, 0});
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b001, 1, 0, 0});
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b010, 1, 1, 0});
    rows.push_back('{0, 3'b111, 6'b000000, 0, 0, 1, 3'b100, 1, 2, 0});
    // ALU alone
    rows.push_back('{0, 3'b001, 6'b000000, 0, 0, 1, 3'b001, 1, 0, 0});
    // backpressure: buffer held, ch1 waits, then replaces on dequeue
    rows.push_back('{0, 3'b010, 6'b000000, 0, 0, 0, 3'b000, 1, 0, 0});
    rows.push_back('{0, 3'b010, 6'b000000, 0, 0, 0, 3'b000, 1, 0, 0});
    rows.push_back('{0, 3'b010, 6'b000000, 0, 0, 0, 3'b000, 1, 0, 0});
    rows.push_back('{0, 3'b010, 6'b000000, 0, 0, 1, 3'b010, 1, 1, 0});
    // ch0 stale drains, ch2 live wins
    rows.push_back('{0, 3'b101, 6'b010000, 1, 0, 1, 3'b101, 1, 2, 1});
    // flush with full buffer and cdb_ready low
    rows.push_back('{0, 3'b010, 6'b000100, 1, 1, 0, 3'b000, 0, 0, 1});
    // pointer did not move during the flush
    rows.push_back('{0, 3'b111, 6'b010101, 1, 0, 1, 3'b001, 1, 0, 1});
    rows.push_back('{0, 3'b000, 6'b000000, 1, 0, 1, 3'b000, 0, 0, 1});
    // two stale in one cycle; stale drain during flush
    rows.push_back('{0, 3'b011, 6'b000000, 1, 0, 1, 3'b011, 0, 0, 3});
    rows.push_back('{0, 3'b100, 6'b000000, 1, 1, 1, 3'b100, 0, 0, 4});
    foreach (rows[i]) apply_row(rows[i]);

    // Mid-stream reset with a full buffer and drop_cnt at 7
    apply_row('{0, 3'b111, 6'b000000, 1, 0, 1, 3'b111, 0, 0, 7});
    apply_row('{0, 3'b001, 6'b000001, 1, 0, 0, 3'b001, 1, 0, 7});
    apply_row('{1, 3'b111, 6'b010101, 1, 0, 0, 3'b000, 0, 0, 0});
    apply_row('{0, 3'b111, 6'b010101, 1, 0, 1, 3'b001, 1, 0, 0});

    // Saturation of the drop counter: three stale drains per cycle
    rst = 1'b0; tb_cur = 2'd1; tb_flush = 1'b0; tb_rdy = 1'b1;
    for (int i = 0; i < N; i++) begin ch_vld[i] = 1'b1; ch_ep[i] = 2'd0; end
    for (int c = 0; c < 21846; c++) tick();
    chk("drop_saturated", bus.drop_cnt, 16'hFFFF);

    // Random traffic; a waiting channel holds its payload until accepted
    rst = 1'b1; tick();
    for (int c = 0; c < 600; c++) begin
      rst      = ($urandom_range(0, 60) == 0);
      tb_flush = ($urandom_range(0, 9) == 0);
      tb_rdy   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) tb_cur = tb_cur + 2'd1;
      for (int i = 0; i < N; i++) begin
        if (!(ch_vld[i] && !seen_ready[i])) begin
          ch_vld[i]  = ($urandom_range(0, 2) != 0);
          ch_ep[i]   = ($urandom_range(0, 4) == 0) ? 2'($urandom) : tb_cur;
          ch_pc[i]   = $urandom;
          ch_uses[i] = 1'($urandom);
          ch_rob[i]  = ROB_W'($urandom);
          ch_prd[i]  = PHYS_W'($urandom);
          ch_data[i] = $urandom;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter downstream of the execution units (ALU, MUL, LSU, branch unit). Each unit presents a buffered result on a valid/ready channel.
- Each cycle the block selects one live result round-robin and registers it into a 1-entry output buffer. That buffer drives the common data bus (CDB) consumed by the ROB, PRF write port and RS wakeup.
- Results whose epoch does not match the current epoch are drained and discarded without reaching the CDB.

Parameters:
- NUM_SRC, 3, number of execution-unit result channels (>=2). Index 0 = ALU.
- ROB_W, package constant, ROB index width.
- PHYS_W, package constant, physical register index width.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- src_valid  in  NUM_SRC  per-channel result valid
- src_ready  out  NUM_SRC  per-channel accept
- src_pc  in  NUM_SRC*32  per-channel PC
- src_uses_rd  in  NUM_SRC  result writes a destination register
- src_rob_idx  in  NUM_SRC*ROB_W  ROB entry
- src_prd_new  in  NUM_SRC*PHYS_W  destination physical register
- src_epoch  in  NUM_SRC*2  epoch tag
- src_data  in  NUM_SRC*32  result value
- cur_epoch  in  2  current epoch, from ROB
- flush  in  1  pipeline flush pulse
- cdb_valid  out  1  CDB broadcast valid
- cdb_ready  in  1  CDB consumer accept
- cdb_pc  out  32  buffered PC
- cdb_uses_rd  out  1  buffered uses_rd
- cdb_rob_idx  out  ROB_W  buffered ROB entry
- cdb_prd_new  out  PHYS_W  buffered destination register
- cdb_data  out  32  buffered result value
- cdb_src  out  $clog2(NUM_SRC)  channel that produced the buffered entry
- drop_cnt  out  CNT_W  saturating count of discarded stale results

Behaviour:
- Reset (rst=1 at posedge):
  - out_vld=0, so cdb_valid=0.
  - All cdb_* payload = 0.
  - rr_ptr=0, drop_cnt=0.
  - src_ready=0 while rst is high.
- Per channel i:
  - stale[i] = src_valid[i] && (src_epoch[i] != cur_epoch).
  - live[i] = src_valid[i] && !stale[i].
- Stale drain: src_ready[i]=1 for every stale channel in the same cycle, independent of buffer state and flush. Each drain increments drop_cnt by 1 (popcount of stale fires per cycle). drop_cnt saturates at all-ones.
- Dequeue: deq = out_vld && cdb_ready.
- Accept condition: can_acc = !flush && (!out_vld || deq).
- Grant:
  - g = first i with live[i], searching from rr_ptr upward with wrap mod NUM_SRC.
  - If can_acc and any live: src_ready[g]=1, and the entry is registered at the next edge (out_vld=1, payload and cdb_src=g).
  - Then rr_ptr = (g+1) mod NUM_SRC.
  - rr_ptr is unchanged when there is no grant.
- Non-granted live channels see src_ready=0 and must hold their payload.
- Latency: src fire at edge N, so cdb_valid is high from cycle N+1. Back-to-back throughput is 1 per cycle while cdb_ready=1.
- Enqueue and dequeue in the same cycle: the new entry replaces the old one and out_vld stays 1.
- Dequeue only: out_vld goes to 0 next cycle.
- While out_vld && !cdb_ready: the payload is held stable and no live channel is granted.
- Flush:
  - The buffer is cleared: out_vld goes to 0 next cycle, even when cdb_ready is low.
  - No live grant that cycle.
  - Stale drain still operates.
  - cur_epoch is updated by the ROB from the following cycle; any results still waiting then become stale and drain.
- The buffered entry is not re-checked against cur_epoch; flush is the only squash path for it.
- src_ready depends combinationally on src_valid, cdb_ready, flush and cur_epoch. src_valid must not depend on src_ready.
- An epoch comparison uses all 2 bits; wrap of the 2-bit epoch is handled by the ROB.
- Reset asserted mid-operation discards the buffered entry.

Decomposition:
- Shared package (defines.svh) holds ROB_W, PHYS_W, and a wb_pkt_t struct {pc, uses_rd, rob_idx, prd_new, epoch, data}. Ports are flattened into the per-field arrays listed above.
- One sub-module, rr_arbiter, parameterised by N:
  - Inputs: req[N], rotation pointer, advance enable.
  - Outputs: one-hot grant, grant index, any-grant flag.
  - Owns the rr_ptr register.

Test Plan:
- ALU only (ch0) valid with data=0x0000_0005, rob_idx=3, epoch=cur=0, cdb_ready=1 -> src_ready[0]=1 same cycle; next cycle cdb_valid=1, cdb_data=5, cdb_rob_idx=3, cdb_src=0.
- All 3 channels continuously live, cdb_ready=1 for 6 cycles -> cdb_src sequence 0,1,2,0,1,2, one grant per cycle.
- Buffer full with cdb_ready=0 for 3 cycles, ch1 live -> cdb_* stable, src_ready[1]=0; when cdb_ready=1 -> src_ready[1]=1 that cycle, new entry next cycle with cdb_valid held 1.
- cur_epoch=1, ch0 epoch=0 valid and ch2 epoch=1 valid -> src_ready[0]=1 and src_ready[2]=1 same cycle, drop_cnt 0->1, only ch2 data appears on the CDB.
- Buffer full, cdb_ready=0, flush=1 with ch1 live -> next cycle cdb_valid=0, src_ready[1]=0 during the flush cycle, rr_ptr unchanged.
- rst=1 mid-stream with buffer full and drop_cnt=7 -> next cycle cdb_valid=0, drop_cnt=0, src_ready all 0 while rst high; first grant after release goes to ch0.
